// File: rtl/gan_stream_pkg.sv
// Shared constants, state encoding and header packing for the GAN result stream.
package gan_stream_pkg;

  localparam int PIXEL_COUNT     = 784;
  localparam int DATA_WIDTH      = 16;
  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam int WORDS_PER_FRAME = PIXEL_COUNT + 3;
  localparam int IDX_WIDTH       = 10;

  localparam int HDR_FAKE_BIT  = 0;
  localparam int HDR_REAL_BIT  = 1;
  localparam int HDR_MAGIC_LSB = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_FAKE = 3'd2,
    ST_REAL = 3'd3,
    ST_PIX  = 3'd4
  } stream_state_t;

  function automatic logic [15:0] make_header(input logic [7:0] magic,
                                              input logic       real_ok,
                                              input logic       fake_ok);
    logic [15:0] hdr;
    hdr = 16'h0000;
    hdr[HDR_MAGIC_LSB +: 8] = magic;
    hdr[HDR_REAL_BIT]       = real_ok;
    hdr[HDR_FAKE_BIT]       = fake_ok;
    return hdr;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Registered valid/ready output stage; contents change only when the owner loads a new word,
// so data/first/last are held while the sink stalls.
module stream_out_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_first,
  output logic                  out_last,
  output logic                  take
);

  assign take = out_valid && out_ready;

  // Output word register; an invalid load returns the port to its idle zero state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= in_valid;
      out_data  <= in_valid ? in_data : '0;
      out_first <= in_valid && in_first;
      out_last  <= in_valid && in_last;
    end
  end

endmodule

// File: rtl/gan_result_streamer.sv
// Captures a completed GAN frame plus discriminator results and streams them as
// header, fake score, real score, then pixels over a valid/ready port.
module gan_result_streamer #(
  parameter int         PIXEL_COUNT = gan_stream_pkg::PIXEL_COUNT,
  parameter int         DATA_WIDTH  = gan_stream_pkg::DATA_WIDTH,
  parameter logic [7:0] HDR_MAGIC   = gan_stream_pkg::HDR_MAGIC
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] generated_frame_flat,
  input  logic                              generated_frame_valid,
  input  logic                              disc_fake_is_real,
  input  logic                              disc_real_is_real,
  input  logic [15:0]                       disc_fake_score,
  input  logic [15:0]                       disc_real_score,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_first,
  output logic                              out_last,
  output logic                              busy,
  output logic                              frame_dropped,
  output logic [7:0]                        drop_count,
  input  logic                              clear_drop
);
  import gan_stream_pkg::*;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(PIXEL_COUNT - 1);

  stream_state_t                    state_r;
  logic [IDX_WIDTH-1:0]             idx_r;
  logic                             busy_r;
  logic                             dropped_r;
  logic [7:0]                       drop_cnt_r;
  logic [DATA_WIDTH*PIXEL_COUNT-1:0] frame_r;
  logic [15:0]                      fake_score_r;
  logic [15:0]                      real_score_r;

  logic                  take_s;
  logic                  last_take_s;
  logic                  capture_s;
  logic                  drop_s;
  logic                  load_s;
  logic                  word_valid_s;
  logic                  word_first_s;
  logic                  word_last_s;
  logic [DATA_WIDTH-1:0] word_s;
  logic [IDX_WIDTH-1:0]  pix_sel_s;

  // Capture/drop decisions; a pulse on the final handshake starts the next frame.
  always_comb begin
    last_take_s = take_s && (state_r == ST_PIX) && (idx_r == LAST_IDX);
    capture_s   = generated_frame_valid && ((state_r == ST_IDLE) || last_take_s);
    drop_s      = generated_frame_valid && busy_r && !capture_s;
  end

  // Next word to present, computed for the state the FSM is moving into.
  always_comb begin
    load_s       = capture_s || take_s;
    word_valid_s = 1'b1;
    word_first_s = 1'b0;
    word_last_s  = 1'b0;
    word_s       = '0;
    pix_sel_s    = '0;
    if (capture_s) begin
      word_s       = DATA_WIDTH'(make_header(HDR_MAGIC, disc_real_is_real, disc_fake_is_real));
      word_first_s = 1'b1;
    end else begin
      case (state_r)
        ST_HDR:  word_s = DATA_WIDTH'(fake_score_r);
        ST_FAKE: word_s = DATA_WIDTH'(real_score_r);
        ST_REAL: begin
          pix_sel_s   = '0;
          word_s      = frame_r[pix_sel_s*DATA_WIDTH +: DATA_WIDTH];
          word_last_s = (pix_sel_s == LAST_IDX);
        end
        ST_PIX: begin
          if (idx_r == LAST_IDX) begin
            word_valid_s = 1'b0;
          end else begin
            pix_sel_s    = idx_r + 10'd1;
            word_s       = frame_r[pix_sel_s*DATA_WIDTH +: DATA_WIDTH];
            word_last_s  = (pix_sel_s == LAST_IDX);
          end
        end
        default: word_valid_s = 1'b0;
      endcase
    end
  end

  // Stream sequencer: state, pixel index and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
      busy_r  <= 1'b0;
    end else if (capture_s) begin
      state_r <= ST_HDR;
      idx_r   <= '0;
      busy_r  <= 1'b1;
    end else if (take_s) begin
      case (state_r)
        ST_HDR:  state_r <= ST_FAKE;
        ST_FAKE: state_r <= ST_REAL;
        ST_REAL: begin
          state_r <= ST_PIX;
          idx_r   <= '0;
        end
        ST_PIX: begin
          if (idx_r == LAST_IDX) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            busy_r  <= 1'b0;
          end else begin
            idx_r <= idx_r + 10'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          idx_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Frame buffer; contents are irrelevant until a capture, so no reset is needed.
  always_ff @(posedge clk) begin
    if (capture_s) begin
      frame_r      <= generated_frame_flat;
      fake_score_r <= disc_fake_score;
      real_score_r <= disc_real_score;
    end
  end

  // Drop bookkeeping; a drop in the clear cycle is recorded after the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropped_r  <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else if (clear_drop) begin
      dropped_r  <= drop_s;
      drop_cnt_r <= drop_s ? 8'd1 : 8'd0;
    end else if (drop_s) begin
      dropped_r <= 1'b1;
      if (drop_cnt_r != 8'hFF) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end
    end
  end

  stream_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .in_valid  (word_valid_s),
    .in_data   (word_s),
    .in_first  (word_first_s),
    .in_last   (word_last_s),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_first (out_first),
    .out_last  (out_last),
    .take      (take_s)
  );

  assign busy          = busy_r;
  assign frame_dropped = dropped_r;
  assign drop_count    = drop_cnt_r;

endmodule

// File: tb/tb_gan_result_streamer.sv
// Scoreboard bench for gan_result_streamer: directed frames pushed to a queue, a monitor checks every accepted word.
module tb_gan_result_streamer;

  localparam int PC = 784;
  localparam int DW = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [DW*PC-1:0] flat = '0;
  logic             gvalid = 1'b0;
  logic             fake_ok = 1'b0;
  logic             real_ok = 1'b0;
  logic [15:0]      fake_sc = 16'h0000;
  logic [15:0]      real_sc = 16'h0000;
  logic [15:0]      out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_first;
  logic             out_last;
  logic             busy;
  logic             frame_dropped;
  logic [7:0]       drop_count;
  logic             clear_drop = 1'b0;

  int n_cmp = 0;
  int n_mis = 0;
  int words_seen = 0;
  bit bp_mode = 1'b0;

  typedef struct packed {
    logic [15:0] data;
    logic        first;
    logic        last;
  } word_t;

  word_t exp_q[$];

  always #5 clk = ~clk;

  gan_result_streamer dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .generated_frame_flat  (flat),
    .generated_frame_valid (gvalid),
    .disc_fake_is_real     (fake_ok),
    .disc_real_is_real     (real_ok),
    .disc_fake_score       (fake_sc),
    .disc_real_score       (real_sc),
    .out_data              (out_data),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .out_first             (out_first),
    .out_last              (out_last),
    .busy                  (busy),
    .frame_dropped         (frame_dropped),
    .drop_count            (drop_count),
    .clear_drop            (clear_drop)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Sink readiness: always ready, or the repeating 1-0-0-1 pattern.
  initial begin : ready_drv
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        out_ready = (ph == 0) || (ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: compare accepted words against the queue and check hold under stall.
  word_t hold_w;
  word_t got_w;
  word_t exp_w;
  bit    stall_pend = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pend = 1'b0;
    end else begin
      got_w = {out_data, out_first, out_last};
      if (stall_pend) begin
        n_cmp++;
        if (!out_valid || got_w !== hold_w) begin
          n_mis++;
          $display("FAIL stall_hold: got v=%0b %h, expected v=1 %h", out_valid, got_w, hold_w);
        end
      end
      stall_pend = out_valid && !out_ready;
      hold_w     = got_w;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_mis++;
          $display("FAIL unexpected_word: got %h, expected no word", got_w.data);
        end else begin
          exp_w = exp_q.pop_front();
          if (got_w !== exp_w) begin
            n_mis++;
            $display("FAIL stream_word: got %h f=%0b l=%0b, expected %h f=%0b l=%0b",
                     got_w.data, got_w.first, got_w.last, exp_w.data, exp_w.first, exp_w.last);
          end
        end
        words_seen++;
      end
    end
  end

  task automatic set_frame(input logic [15:0] base);
    for (int i = 0; i < PC; i++) flat[i*DW +: DW] = base + 16'(i);
  endtask

  task automatic push_frame(input logic [15:0] base, input logic [15:0] fs, input logic [15:0] rs,
                            input logic rok, input logic fok);
    exp_q.push_back({8'hA5, 6'b000000, rok, fok, 1'b1, 1'b0});
    exp_q.push_back({fs, 1'b0, 1'b0});
    exp_q.push_back({rs, 1'b0, 1'b0});
    for (int i = 0; i < PC; i++) exp_q.push_back({base + 16'(i), 1'b0, (i == PC - 1)});
  endtask

  // Called just after a rising edge; returns just after the capture edge.
  task automatic send_frame(input logic [15:0] base, input logic [15:0] fs, input logic [15:0] rs,
                            input logic rok, input logic fok, input bit expect_it);
    set_frame(base);
    fake_sc = fs;
    real_sc = rs;
    real_ok = rok;
    fake_ok = fok;
    if (expect_it) push_frame(base, fs, rs, rok, fok);
    gvalid = 1'b1;
    @(posedge clk);
    #1;
    gvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 5000) begin
      n_cmp++;
      n_mis++;
      $display("FAIL %s_timeout: got %0d words pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin : main
    int ws0;
    int cyc;
    #1;
    check("rst_valid", out_valid, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_first_last", {out_first, out_last}, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_dropped", frame_dropped, 32'd0);
    check("rst_drop_count", drop_count, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame, sink always ready.
    ws0 = words_seen;
    send_frame(16'h0100, 16'hFFFB, 16'h000C, 1'b1, 1'b0, 1'b1);
    check("hdr_valid", out_valid, 32'd1);
    check("hdr_data", out_data, 32'h0000A502);
    check("hdr_first", out_first, 32'd1);
    check("busy_set", busy, 32'd1);
    wait_drain("basic");
    check("basic_words", words_seen - ws0, 32'd787);
    check("busy_clear", busy, 32'd0);

    // Backpressure.
    bp_mode = 1'b1;
    ws0 = words_seen;
    send_frame(16'h0100, 16'hFFFB, 16'h000C, 1'b1, 1'b0, 1'b1);
    wait_drain("backpressure");
    bp_mode = 1'b0;
    check("bp_words", words_seen - ws0, 32'd787);

    // Single drop 100 cycles into a stream; buffer must stay intact.
    ws0 = words_seen;
    send_frame(16'h0100, 16'hFFFB, 16'h000C, 1'b1, 1'b0, 1'b1);
    repeat (99) @(posedge clk);
    #1;
    send_frame(16'h7700, 16'h1111, 16'h2222, 1'b0, 1'b1, 1'b0);
    check("drop_flag", frame_dropped, 32'd1);
    check("drop_count1", drop_count, 32'd1);
    wait_drain("drop_frame");
    check("drop_frame_words", words_seen - ws0, 32'd787);

    // Saturation, clear, and clear racing a drop.
    send_frame(16'h0500, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1);
    gvalid = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    gvalid = 1'b0;
    check("drop_sat", drop_count, 32'd255);
    clear_drop = 1'b1;
    @(posedge clk);
    #1;
    clear_drop = 1'b0;
    check("clear_count", drop_count, 32'd0);
    check("clear_flag", frame_dropped, 32'd0);
    clear_drop = 1'b1;
    gvalid = 1'b1;
    @(posedge clk);
    #1;
    clear_drop = 1'b0;
    gvalid = 1'b0;
    check("clear_with_drop_count", drop_count, 32'd1);
    check("clear_with_drop_flag", frame_dropped, 32'd1);
    clear_drop = 1'b1;
    @(posedge clk);
    #1;
    clear_drop = 1'b0;
    check("clear_again", drop_count, 32'd0);
    wait_drain("sat_frame");

    // Back-to-back: second pulse on the final-word handshake cycle.
    send_frame(16'h1000, 16'h0010, 16'h0020, 1'b1, 1'b1, 1'b1);
    repeat (786) @(posedge clk);
    #1;
    check("b2b_last_present", out_last, 32'd1);
    send_frame(16'h2000, 16'hFFFF, 16'h7FFF, 1'b0, 1'b0, 1'b1);
    check("b2b_hdr_first", out_first, 32'd1);
    check("b2b_hdr_data", out_data, 32'h0000A500);
    check("b2b_no_drop", drop_count, 32'd0);
    wait_drain("b2b");

    // Reset mid-stream at word 400.
    ws0 = words_seen;
    send_frame(16'h3000, 16'h0A0A, 16'hF0F0, 1'b1, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    gvalid = 1'b1;
    @(posedge clk);
    #1;
    gvalid = 1'b0;
    check("pre_rst_drop", drop_count, 32'd1);
    cyc = 0;
    while ((words_seen - ws0) < 400 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_point_reached", ((words_seen - ws0) >= 400), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    check("mid_rst_first_last", {out_first, out_last}, 32'd0);
    check("mid_rst_busy", busy, 32'd0);
    check("mid_rst_flag", frame_dropped, 32'd0);
    check("mid_rst_count", drop_count, 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ws0 = words_seen;
    send_frame(16'h4000, 16'h1234, 16'h5678, 1'b0, 1'b1, 1'b1);
    check("post_rst_hdr", out_data, 32'h0000A501);
    wait_drain("post_rst");
    check("post_rst_words", words_seen - ws0, 32'd787);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
